// File: rtl/regfile_pkg.sv
// Shared sizing helpers and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    function automatic int unsigned addr_width(input int unsigned nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int unsigned AW_DEF = addr_width(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve at issue, clear at writeback, flush on squash.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREG = NREG_DEF,
    parameter  int unsigned NWR  = 1,
    localparam int unsigned AW   = addr_width(NREG)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
    input  logic [NWR-1:0]           wr_clr_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
    input  logic                     flush_i,
    output logic [NREG-1:0]          busy_vec_o,
    output logic [NREG-1:0]          clr_hit_o
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        clr_hit_o = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && wr_clr_i[p]) begin
                clr_hit_o[wr_addr_i[p]] = 1'b1;
            end
        end
        clr_hit_o[0] = 1'b0;
    end

    // Applied lowest to highest priority: clear, then reserve, then flush.
    always_comb begin
        busy_d = busy_q & ~clr_hit_o;
        if (rsv_en_i) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREG   = NREG_DEF,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned NWR    = 1,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = addr_width(NREG)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
    input  logic [NWR-1:0]           wr_clr_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
    input  logic                     flush_i,
    output logic [NREG-1:0]          busy_vec_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] clr_hit;

    assign regs[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [XLEN-1:0] reg_q, reg_d;

        // Later ports overwrite earlier ones, so the highest index wins.
        always_comb begin
            reg_d = reg_q;
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p] == AW'(r))) begin
                    reg_d = wr_data_i[p];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[r] = reg_q;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        always_comb begin
            rd_data_o[i] = regs[rd_addr_i[i]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en_i[p] && (wr_addr_i[p] == rd_addr_i[i])) begin
                        rd_data_o[i] = wr_data_i[p];
                    end
                end
            end
            if (rd_addr_i[i] == '0) begin
                rd_data_o[i] = '0;
            end
        end

        always_comb begin
            rd_busy_o[i] = busy_vec_o[rd_addr_i[i]];
            if ((BYPASS != 0) && clr_hit[rd_addr_i[i]]) begin
                rd_busy_o[i] = 1'b0;
            end
            if (rd_addr_i[i] == '0) begin
                rd_busy_o[i] = 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_clr_i   (wr_clr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .flush_i    (flush_i),
        .busy_vec_o (busy_vec_o),
        .clr_hit_o  (clr_hit)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus, checked against a model.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic                     clk;
    logic                     rst_n;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           wr_clr;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     flush;

    logic [NRD-1:0][XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]           rd_busy_b, rd_busy_n;
    logic [NREG-1:0]          busy_vec_b, busy_vec_n;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_clr_i(wr_clr), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .busy_vec_o(busy_vec_b)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)
    ) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .rd_busy_o(rd_busy_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_clr_i(wr_clr), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .busy_vec_o(busy_vec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: register values and busy bits.
    logic [XLEN-1:0] mreg  [NREG];
    logic            mbusy [NREG];

    function automatic logic clr_hit(input int r);
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_clr[p] && wr_addr[p] == AW'(r)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mreg[r]  <= '0;
                mbusy[r] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p] != 0) mreg[wr_addr[p]] <= wr_data[p];
            for (int r = 1; r < NREG; r++) begin
                if (flush)                                 mbusy[r] <= 1'b0;
                else if (rsv_en && rsv_addr == AW'(r))     mbusy[r] <= 1'b1;
                else if (clr_hit(r))                       mbusy[r] <= 1'b0;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp)
            for (int p = NWR - 1; p >= 0; p--)
                if (wr_en[p] && wr_addr[p] == a) return wr_data[p];
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        return mbusy[a] && !(byp && clr_hit(int'(a)));
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = mbusy[r];
        return v;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("model rd_data_b[%0d]", i), rd_data_b[i], exp_data(rd_addr[i], 1'b1));
            chk($sformatf("model rd_data_n[%0d]", i), rd_data_n[i], exp_data(rd_addr[i], 1'b0));
            chk($sformatf("model rd_busy_b[%0d]", i), 32'(rd_busy_b[i]),
                32'(exp_busy(rd_addr[i], 1'b1)));
            chk($sformatf("model rd_busy_n[%0d]", i), 32'(rd_busy_n[i]),
                32'(exp_busy(rd_addr[i], 1'b0)));
        end
        chk("model busy_vec_b", busy_vec_b, exp_vec());
        chk("model busy_vec_n", busy_vec_n, exp_vec());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        wr_clr = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic clr);
        wr_en[p]   = 1'b1;
        wr_addr[p] = a;
        wr_data[p] = d;
        wr_clr[p]  = clr;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        rd_addr[0] = 5'd5;
        #1;
        chk("reset rd x5", rd_data_b[0], 32'h0);
        chk("reset busy_vec", busy_vec_b, 32'h0);

        // Mid-run asynchronous reset
        wr(0, 5'd5, 32'hDEAD, 1'b0);
        rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle();
        chk("x5 written", rd_data_b[0], 32'hDEAD);
        chk("x5 written nb", rd_data_n[0], 32'hDEAD);
        chk("x6 reserved", busy_vec_b, 32'h40);
        rst_n = 1'b0;
        #1;
        chk("async rst rd x5", rd_data_b[0], 32'h0);
        chk("async rst rd x5 nb", rd_data_n[0], 32'h0);
        chk("async rst busy_vec", busy_vec_b, 32'h0);
        rst_n = 1'b1;
        tick();

        // x0 stays zero and never busy
        wr(0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_addr[0] = 5'd0;
        #1;
        chk("x0 bypass rd", rd_data_b[0], 32'h0);
        chk("x0 rd_busy", 32'(rd_busy_b[0]), 32'h0);
        tick();
        idle();
        chk("x0 busy_vec", busy_vec_b, 32'h0);

        // Bypass vs registered read
        wr(0, 5'd3, 32'h1234, 1'b0);
        rd_addr[1] = 5'd3;
        #1;
        chk("bypass x3", rd_data_b[1], 32'h1234);
        chk("no-bypass x3 old", rd_data_n[1], 32'h0);
        tick();
        idle();
        chk("no-bypass x3 new", rd_data_n[1], 32'h1234);

        // Port conflict: highest port wins
        wr(0, 5'd7, 32'hA, 1'b0);
        wr(1, 5'd7, 32'hB, 1'b0);
        rd_addr[0] = 5'd7;
        #1;
        chk("conflict bypass x7", rd_data_b[0], 32'hB);
        tick();
        idle();
        chk("conflict x7", rd_data_b[0], 32'hB);
        chk("conflict x7 nb", rd_data_n[0], 32'hB);

        // Scoreboard reserve / clear
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rd_addr[0] = 5'd9;
        #1;
        chk("rsv no same-cycle busy", 32'(rd_busy_b[0]), 32'h0);
        tick();
        idle();
        chk("x9 busy", busy_vec_b, 32'h200);
        chk("x9 rd_busy", 32'(rd_busy_b[0]), 32'h1);
        wr(1, 5'd9, 32'h99, 1'b1);
        #1;
        chk("clr bypass rd_busy", 32'(rd_busy_b[0]), 32'h0);
        chk("clr no-bypass rd_busy", 32'(rd_busy_n[0]), 32'h1);
        tick();
        idle();
        chk("x9 cleared", busy_vec_b, 32'h0);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr(0, 5'd9, 32'h98, 1'b1);
        tick();
        idle();
        chk("rsv beats clr", busy_vec_b, 32'h200);

        // wr_clr without wr_en is ignored
        wr_clr[0] = 1'b1; wr_addr[0] = 5'd9;
        tick();
        idle();
        chk("clr w/o en", busy_vec_n, 32'h200);

        // Flush beats reserve
        for (int r = 1; r <= 3; r++) begin
            rsv_en = 1'b1; rsv_addr = AW'(r);
            tick();
        end
        idle();
        chk("multi rsv", busy_vec_b, 32'h20E);
        flush = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        idle();
        chk("flush", busy_vec_b, 32'h0);

        // Mixed traffic, checked by the model every cycle
        for (int i = 1; i <= 10; i++) begin
            wr(i % 2, AW'(i + 10), 32'h1111_1111 * i, 1'b0);
            rd_addr[0] = AW'(i + 10);
            rd_addr[1] = AW'(i + 9);
            rsv_en   = (i % 3 == 0);
            rsv_addr = AW'(i + 12);
            tick();
            idle();
        end
        rd_addr[0] = 5'd14;
        #1;
        chk("x14 final", rd_data_n[0], 32'h4444_4444);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
